uart_tx_fifo: RTL
=================

# uart_tx_fifo

Buffered UART transmitter consuming the one-cycle character pulses produced by the data-memory block's simulated UART port (store to 0x10000000). It queues characters in a small FIFO and serializes them as 8N1 frames on a physical `tx` line, so board builds emit the same character stream the simulation prints. It sits directly downstream of the data memory, in the same `clka` domain.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥ 2.
- `FIFO_DEPTH`, 16: character buffer entries; power of two, ≥ 2.

Ports:
- `clka`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `char_in`  in  8: character byte, sampled only when `char_valid` = 1.
- `char_valid`  in  1: one-cycle push strobe, driven by the memory's UART-valid output.
- `clear_overflow`  in  1: clears the sticky `overflow` flag.
- `tx`  out  1: serial line; idle-high.
- `busy`  out  1: high while a frame is on the line.
- `fifo_empty`  out  1: FIFO holds no characters.
- `fifo_full`  out  1: FIFO holds `FIFO_DEPTH` characters.
- `overflow`  out  1: sticky flag; a push was dropped.

## Operation
- Push: accepted iff `char_valid` && !`fifo_full`, judged on the registered count. When full, the push is dropped even if a pop occurs in the same cycle; `overflow` is then set.
- `overflow`: set on a drop; cleared by `clear_overflow`; set wins when both occur in the same cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if !`fifo_empty`, pop the head into an 8-bit shift register, enter START, load the bit counter.
  - START: `tx` = 0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first, `CLKS_PER_BIT` cycles each; a 3-bit index advances 0..7.
  - STOP: `tx` = 1 for `CLKS_PER_BIT` cycles. On the last stop cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Divider: counts 0..`CLKS_PER_BIT`-1 and wraps; a bit boundary occurs at the wrap.
- FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap naturally. Count is log2(`FIFO_DEPTH`)+1 bits. Simultaneous push and pop leaves the count unchanged.
- `busy` = 1 in START/DATA/STOP; `tx` is registered.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `fifo_empty` = 1, `fifo_full` = 0, `overflow` = 0. FSM = IDLE, pointers, count and divider = 0.
- Reset mid-frame: the frame is abandoned, `tx` = 1 after the reset edge, and FIFO contents are discarded.
- Latency (line idle, FIFO empty): `char_valid` sampled at edge k → `fifo_empty` falls after edge k. Pop occurs at edge k+1; `tx` falls and `busy` rises after edge k+1.
- Frame length: exactly 10·`CLKS_PER_BIT` cycles. Back-to-back frames are contiguous.
- Status flags reflect the registered count and update one edge after a push or pop.

## Structure
- Shared package `uart_pkg`: FSM state enum `uart_tx_state_t`, frame constants (`UART_DATA_BITS` = 8, `UART_FRAME_BITS` = 10), and `SIM_UART_ADDR` = 32'h10000000, reused by the memory and address decode.
- One sub-module, `sync_fifo` (parameterized width/depth; push/pop/full/empty/count). The FSM, divider and shift register stay in the top level.

## Test plan
- Reset, `CLKS_PER_BIT` = 4: push 0x41 → `tx` low 4 cycles; bits 1,0,0,0,0,0,1,0 at 4 cycles each; high 4 cycles; `busy` high exactly 40 cycles. `tx` falls after the edge following the push edge.
- Push 0x48, 0x69, 0x0A on consecutive cycles → three contiguous frames, 120 cycles total, LSB-first payloads match. `fifo_empty` rises after the third pop; `busy` falls after cycle 120.
- `FIFO_DEPTH` = 16: push 18 characters on consecutive cycles → first 17 accepted (one popped at edge 1), 18th dropped. `overflow` = 1, `fifo_full` = 1. Serialized output equals characters 0..16.
- With `overflow` = 1: assert `clear_overflow` together with a dropped push → `overflow` stays 1. Assert `clear_overflow` alone → `overflow` = 0 next cycle.
- Assert `rst` in the middle of DATA bit 3 with 5 characters queued → next cycle `tx` = 1, `busy` = 0, `fifo_empty` = 1. A fresh push 0x55 afterwards produces a clean frame.
- Push 0xFF and 0x00 → frame 1: `tx` low only during START. Frame 2: low for START plus 8 data bits (36 cycles at `CLKS_PER_BIT` = 4), then a 4-cycle stop.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame geometry, simulated UART address.
// No logic; imported by the transmitter, the data memory and the address decode.
// Backpressure: none.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  localparam logic [31:0] SIM_UART_ADDR = 32'h1000_0000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pop_dat shows the head combinationally.
// Latency: a push is visible at the head one edge later.
// Backpressure: a push while full and a pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clka) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
  always_ff @(posedge clka) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter fed by one-cycle character strobes.
// Latency: push at edge k, start bit on tx after edge k+1; 10*CLKS_PER_BIT cycles per frame.
// Backpressure: none upstream; pushes into a full FIFO are dropped and flagged in sticky overflow.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clka,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  input  logic       clear_overflow,
  output logic       tx,
  output logic       busy,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t state, state_nxt;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_nxt;
  logic [7:0]       head_dat;
  logic [CNT_W-1:0] fifo_cnt;
  logic             div_wrap;
  logic             has_char;
  logic             last_bit;
  logic             pop_head;
  logic             tx_d;

  assign div_wrap = (div_cnt == DIV_W'(CLKS_PER_BIT - 1));
  assign has_char = (fifo_cnt != '0);
  assign last_bit = (bit_idx == 3'(UART_DATA_BITS - 1));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clka     (clka),
    .rst      (rst),
    .push     (char_valid),
    .push_dat (char_in),
    .pop      (pop_head),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clka) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (has_char)             state_nxt = ST_START;
      ST_START: if (div_wrap)             state_nxt = ST_DATA;
      ST_DATA:  if (div_wrap && last_bit) state_nxt = ST_STOP;
      ST_STOP:  if (div_wrap)             state_nxt = has_char ? ST_START : ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  // tx is computed from the next state so the registered line lines up with the state register.
  always_comb begin
    busy     = (state != ST_IDLE);
    pop_head = has_char && ((state == ST_IDLE) || ((state == ST_STOP) && div_wrap));
    if (pop_head)                             shift_nxt = head_dat;
    else if ((state == ST_DATA) && div_wrap)  shift_nxt = {1'b0, shift_reg[7:1]};
    else                                      shift_nxt = shift_reg;
    case (state_nxt)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_nxt[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      div_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      div_cnt   <= ((state == ST_IDLE) || div_wrap) ? '0 : div_cnt + 1'b1;
      shift_reg <= shift_nxt;
      tx        <= tx_d;
      if (pop_head)                            bit_idx <= '0;
      else if ((state == ST_DATA) && div_wrap) bit_idx <= bit_idx + 1'b1;
      // A drop in the same cycle as a clear keeps the flag set.
      if (char_valid && fifo_full) overflow <= 1'b1;
      else if (clear_overflow)     overflow <= 1'b0;
    end
  end

endmodule
